// File: rtl/sayeh_page_ctrl.sv
// Demand-paged memory front end: FRAMES resident pages with round-robin victims,
// dirty writeback and explicit flush. Define PAGE_STATS_EN for hit/miss/writeback counters.
module sayeh_page_ctrl #(
    parameter int TOTAL_ADDR_LEN = 16,
    parameter int PAGE_LEN       = 4,
    parameter int FRAMES         = 2
) (
    input  logic                      clk,
    input  logic                      ExternalReset_n,
    input  logic                      ReadMem,
    input  logic                      WriteMem,
    input  logic [TOTAL_ADDR_LEN-1:0] Addressbus,
    input  logic [15:0]               DataIn,
    output logic [15:0]               DataOut,
    output logic                      MemDataready,
    input  logic                      flush_req,
    output logic                      flush_done,
    output logic                      bs_req,
    output logic                      bs_we,
    output logic [TOTAL_ADDR_LEN-1:0] bs_addr,
    output logic [15:0]               bs_wdata,
    input  logic [15:0]               bs_rdata,
    input  logic                      bs_ack,
    output logic [15:0]               hit_count,
    output logic [15:0]               miss_count,
    output logic [15:0]               wb_count
);
    localparam int OFF   = TOTAL_ADDR_LEN - PAGE_LEN;
    localparam int FI    = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int DEPTH = FRAMES << OFF;

    typedef enum logic [2:0] {IDLE, WRITEBACK, FILL, SERVE, FLUSH} state_t;

    state_t              state_q, state_d;
    logic [FRAMES-1:0]   valid_q, valid_d, dirty_q, dirty_d;
    logic [PAGE_LEN-1:0] tag_q [FRAMES];
    logic [PAGE_LEN-1:0] tag_d [FRAMES];
    logic [FI-1:0]       vptr_q, vptr_d, frm_q, frm_d;
    logic [OFF-1:0]      cnt_q, cnt_d, roff_q, roff_d;
    logic [PAGE_LEN-1:0] rpage_q, rpage_d;
    logic [15:0]         rdat_q, rdat_d, dout_q, dout_d;
    logic                rwe_q, rwe_d, drop_q, drop_d;
    logic                rdy_q, rdy_d, fdone_q, fdone_d;

    logic [15:0]         mem [DEPTH];
    logic                mem_we;
    logic [FI+OFF-1:0]   mem_waddr, rd_idx;
    logic [15:0]         mem_wdata, rd_word;

    logic [PAGE_LEN-1:0] a_page;
    logic [OFF-1:0]      a_off;
    logic                hit, cnt_last;
    logic [FI-1:0]       hit_frm;
    logic [FRAMES-1:0]   pend, pend_rest;

    function automatic logic [FI-1:0] first_set(input logic [FRAMES-1:0] m);
        first_set = '0;
        for (int i = FRAMES - 1; i >= 0; i--)
            if (m[i]) first_set = FI'(i);
    endfunction

    assign a_page    = Addressbus[TOTAL_ADDR_LEN-1 -: PAGE_LEN];
    assign a_off     = Addressbus[OFF-1:0];
    assign cnt_last  = &cnt_q;
    assign pend      = valid_q & dirty_q;
    assign pend_rest = pend & ~(FRAMES'(1) << frm_q);

    always_comb begin
        hit     = 1'b0;
        hit_frm = '0;
        for (int i = 0; i < FRAMES; i++)
            if (valid_q[i] && tag_q[i] == a_page) begin
                hit     = 1'b1;
                hit_frm = FI'(i);
            end
    end

    // Single read port: hit lookup in IDLE, pending word in SERVE, else the transfer word.
    always_comb begin
        case (state_q)
            IDLE:    rd_idx = {hit_frm, a_off};
            SERVE:   rd_idx = {frm_q, roff_q};
            default: rd_idx = {frm_q, cnt_q};
        endcase
    end
    assign rd_word  = mem[rd_idx];
    assign bs_wdata = rd_word;

    always_comb begin
        bs_req  = 1'b0;
        bs_we   = 1'b0;
        bs_addr = '0;
        case (state_q)
            WRITEBACK, FLUSH: begin
                bs_req  = 1'b1;
                bs_we   = 1'b1;
                bs_addr = {tag_q[frm_q], cnt_q};
            end
            FILL: begin
                bs_req  = 1'b1;
                bs_addr = {rpage_q, cnt_q};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        dirty_d   = dirty_q;
        tag_d     = tag_q;
        vptr_d    = vptr_q;
        frm_d     = frm_q;
        cnt_d     = cnt_q;
        roff_d    = roff_q;
        rpage_d   = rpage_q;
        rdat_d    = rdat_q;
        rwe_d     = rwe_q;
        drop_d    = drop_q;
        dout_d    = dout_q;
        rdy_d     = 1'b0;
        fdone_d   = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = {frm_q, cnt_q};
        mem_wdata = bs_rdata;
        case (state_q)
            IDLE: begin
                if (WriteMem || ReadMem) begin
                    if (hit) begin
                        rdy_d = 1'b1;
                        if (WriteMem) begin
                            mem_we           = 1'b1;
                            mem_waddr        = {hit_frm, a_off};
                            mem_wdata        = DataIn;
                            dirty_d[hit_frm] = 1'b1;
                        end else begin
                            dout_d = rd_word;
                        end
                    end else begin
                        rpage_d = a_page;
                        roff_d  = a_off;
                        rdat_d  = DataIn;
                        rwe_d   = WriteMem;
                        drop_d  = 1'b0;
                        frm_d   = vptr_q;
                        cnt_d   = '0;
                        state_d = (valid_q[vptr_q] && dirty_q[vptr_q]) ? WRITEBACK : FILL;
                    end
                end else if (flush_req) begin
                    if (pend == '0) begin
                        fdone_d = 1'b1;
                    end else begin
                        frm_d   = first_set(pend);
                        cnt_d   = '0;
                        state_d = FLUSH;
                    end
                end
            end
            WRITEBACK: begin
                if (!ReadMem && !WriteMem) drop_d = 1'b1;
                if (bs_ack) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_last) state_d = FILL;
                end
            end
            FILL: begin
                if (!ReadMem && !WriteMem) drop_d = 1'b1;
                if (bs_ack) begin
                    mem_we = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_last) begin
                        tag_d[frm_q]   = rpage_q;
                        valid_d[frm_q] = 1'b1;
                        dirty_d[frm_q] = 1'b0;
                        vptr_d         = (vptr_q == FI'(FRAMES - 1)) ? '0 : vptr_q + 1'b1;
                        state_d        = SERVE;
                    end
                end
            end
            SERVE: begin
                state_d = IDLE;
                // A request withdrawn during the transfer leaves the page resident but is not performed.
                if (!drop_q) begin
                    rdy_d = 1'b1;
                    if (rwe_q) begin
                        mem_we         = 1'b1;
                        mem_waddr      = {frm_q, roff_q};
                        mem_wdata      = rdat_q;
                        dirty_d[frm_q] = 1'b1;
                    end else begin
                        dout_d = rd_word;
                    end
                end
            end
            FLUSH: begin
                if (bs_ack) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_last) begin
                        dirty_d[frm_q] = 1'b0;
                        if (pend_rest == '0) begin
                            fdone_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            frm_d = first_set(pend_rest);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!ExternalReset_n) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < FRAMES; i++) tag_q[i] <= '0;
            vptr_q  <= '0;
            frm_q   <= '0;
            cnt_q   <= '0;
            roff_q  <= '0;
            rpage_q <= '0;
            rdat_q  <= '0;
            rwe_q   <= 1'b0;
            drop_q  <= 1'b0;
            dout_q  <= '0;
            rdy_q   <= 1'b0;
            fdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            tag_q   <= tag_d;
            vptr_q  <= vptr_d;
            frm_q   <= frm_d;
            cnt_q   <= cnt_d;
            roff_q  <= roff_d;
            rpage_q <= rpage_d;
            rdat_q  <= rdat_d;
            rwe_q   <= rwe_d;
            drop_q  <= drop_d;
            dout_q  <= dout_d;
            rdy_q   <= rdy_d;
            fdone_q <= fdone_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && ExternalReset_n) mem[mem_waddr] <= mem_wdata;
    end

    assign DataOut      = dout_q;
    assign MemDataready = rdy_q;
    assign flush_done   = fdone_q;

`ifdef PAGE_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d, wb_cnt_q, wb_cnt_d;
    logic        idle_req, wb_word;

    assign idle_req = (state_q == IDLE) && (ReadMem || WriteMem);
    assign wb_word  = (state_q == WRITEBACK || state_q == FLUSH) && bs_ack && cnt_last;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        wb_cnt_d   = wb_cnt_q;
        if (idle_req && hit && hit_cnt_q != 16'hFFFF)    hit_cnt_d  = hit_cnt_q + 1'b1;
        if (idle_req && !hit && miss_cnt_q != 16'hFFFF)  miss_cnt_d = miss_cnt_q + 1'b1;
        if (wb_word && wb_cnt_q != 16'hFFFF)             wb_cnt_d   = wb_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!ExternalReset_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            wb_cnt_q   <= wb_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
    assign wb_count   = wb_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
    assign wb_count   = '0;
`endif

endmodule

// File: doc/sayeh_page_ctrl.md
SAYEH_PAGE_CTRL -- requirements
Module: sayeh_page_ctrl

Interface
REQ-001 SHALL have parameter TOTAL_ADDR_LEN, default 16, CPU address width in bits.
REQ-002 SHALL have parameter PAGE_LEN, default 4, page-number bits taken from the top of the address; offset width OFF = TOTAL_ADDR_LEN-PAGE_LEN.
REQ-003 SHALL have parameter FRAMES, default 2, number of resident page frames, power of 2, range 1..8.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port ExternalReset_n, input, 1, reset that is synchronous and active-low.
REQ-006 SHALL have ports ReadMem and WriteMem, each input, 1, CPU read and write request.
REQ-007 SHALL have port Addressbus, input, TOTAL_ADDR_LEN, CPU virtual address = {page, offset}.
REQ-008 SHALL have port DataIn, input, 16, write data, and port DataOut, output, 16, read data.
REQ-009 SHALL have port MemDataready, output, 1, a one-cycle completion pulse.
REQ-010 SHALL have port flush_req, input, 1, request to write back all dirty frames, and port flush_done, output, 1, a one-cycle pulse when the flush is complete.
REQ-011 SHALL have backing-store ports bs_req (output, 1), bs_we (output, 1), bs_addr (output, TOTAL_ADDR_LEN), bs_wdata (output, 16), bs_rdata (input, 16) and bs_ack (input, 1).
REQ-012 SHALL have ports hit_count, miss_count and wb_count, each output, 16.

Function
REQ-013 SHALL hold per frame: storage of 2^OFF x 16, a PAGE_LEN-bit tag, a valid bit and a dirty bit, plus a round-robin victim pointer of log2(FRAMES) bits.
REQ-014 SHALL implement FSM states IDLE, WRITEBACK, FILL, SERVE and FLUSH.
REQ-015 SHALL, in IDLE, sample one request per cycle; WriteMem has priority over ReadMem; flush_req is taken only when neither ReadMem nor WriteMem is high.
REQ-016 SHALL, on a hit (valid frame whose tag equals Addressbus page), pulse MemDataready in the next cycle.
REQ-017 SHALL, on a read hit, present DataOut together with MemDataready.
REQ-018 SHALL, on a write hit, store DataIn at the sampled edge and set the frame's dirty bit.
REQ-019 SHALL, on a miss with the victim frame valid and dirty, enter WRITEBACK: bs_req=1, bs_we=1, bs_addr={victim tag, cnt}, with cnt running 0..2^OFF-1 and advancing only on bs_ack.
REQ-020 SHALL, on a miss with the victim clean or invalid, or after WRITEBACK, enter FILL: bs_req=1, bs_we=0, bs_addr={requested page, cnt}, capturing bs_rdata on each bs_ack.
REQ-021 SHALL, after the last FILL word, set the frame's tag, valid=1 and dirty=0, advance the victim pointer by 1 (wrapping at FRAMES), and go to SERVE.
REQ-022 SHALL, in SERVE, complete the pending request as a hit and then return to IDLE.
REQ-023 SHALL latch the request address, data and type at the miss, and take no new request until MemDataready.
REQ-024 SHALL, when ReadMem and WriteMem are deasserted mid-miss, still complete the transfer, but complete it without a MemDataready pulse.
REQ-025 SHALL, in FLUSH, write back every valid dirty frame in index order, clear those dirty bits, keep all valid bits, and pulse flush_done once; with no dirty frames, flush_done pulses one cycle after the request.
REQ-026 SHALL hold bs_req high and bs_addr stable until bs_ack; bs_req SHALL be low outside WRITEBACK, FILL and FLUSH.

Reset
REQ-027 SHALL, while ExternalReset_n=0 at a rising edge, go to IDLE; clear all valid, dirty, victim pointer, counters, MemDataready, flush_done and bs_req; and drive DataOut=0.
REQ-028 SHALL, on reset mid-transfer, abandon the transfer immediately with no further bs_req; frame storage contents are not cleared.

Configuration
REQ-029 SHALL, with PAGE_STATS_EN defined, run hit_count, miss_count and wb_count as 16-bit saturating counters (saturating at 16'hFFFF), incremented per hit, per miss, and per frame written back (including flush).
REQ-030 SHALL, without PAGE_STATS_EN, tie the three counter outputs to 0 and include no counter logic.

Verification (TOTAL_ADDR_LEN=8, PAGE_LEN=4, FRAMES=2, bs_ack every cycle)
REQ-031 SHALL cover: read 0x35 after reset -> FILL reads bs_addr 0x30..0x3F, then MemDataready with DataOut = backing[0x35]; miss_count=1.
REQ-032 SHALL cover: write 0x35=0xBEEF, then read 0x35 -> read is a hit with MemDataready one cycle after the request, DataOut=0xBEEF, hit_count=2.
REQ-033 SHALL cover: with pages 3 (dirty) and 5 resident, read 0x70 -> victim frame 0 is written back at bs_addr 0x30..0x3F with backing[0x35]=0xBEEF, then page 7 is filled; wb_count=1.
REQ-034 SHALL cover: flush_req with frame 1 dirty holding page 5 -> writeback at 0x50..0x5F, then one flush_done pulse; frame 1 dirty=0 and valid=1.
REQ-035 SHALL cover: reset asserted at FILL word 6 -> bs_req low on the next cycle; a following read of the same page is a miss that refills from 0x_0.
REQ-036 SHALL cover: ReadMem and WriteMem both high on a hit -> a write is performed and DataOut is not updated.
